// File: rtl/mult_sched_if.sv
// mult_sched_if
//   Bundles the requester-side and multiplier-core-side signals of the
//   shared-multiplier scheduler.
//   master : the environment (requesting units and the multiplier core)
//   slave  : the scheduler itself
// Signals
//   req        requester -> sched   per-requester request level
//   a_in/b_in  requester -> sched   packed operands, requester k at [k*W +: W]
//   gnt        sched -> requester   one-hot grant, held for the whole service
//   res_valid  sched -> requester   one-hot, one-cycle result pulse
//   res_out    sched -> requester   2W-bit product, held until the next result
//   busy       sched -> requester   high while an operation is in progress
//   mul_load   sched -> core        one-cycle load/clear pulse
//   mul_a/b    sched -> core        latched operands
//   mul_p      core  -> sched       product from the core
interface mult_sched_if #(
  parameter int NREQ = 4,
  parameter int W    = 8
);
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] a_in;
  logic [NREQ*W-1:0] b_in;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   res_valid;
  logic [2*W-1:0]    res_out;
  logic              busy;
  logic              mul_load;
  logic [W-1:0]      mul_a;
  logic [W-1:0]      mul_b;
  logic [2*W-1:0]    mul_p;

  modport master (
    output req, a_in, b_in, mul_p,
    input  gnt, res_valid, res_out, busy, mul_load, mul_a, mul_b
  );

  modport slave (
    input  req, a_in, b_in, mul_p,
    output gnt, res_valid, res_out, busy, mul_load, mul_a, mul_b
  );
endinterface

// File: rtl/mult_sched.sv
// mult_sched
//   Round-robin scheduler sharing one sequential shift-add multiplier among
//   NREQ requesters. It picks the next pending requester at or after the
//   round-robin pointer, latches its operands, pulses the core's load input,
//   waits the fixed core latency and hands the product back with a one-cycle
//   valid pulse.
// Parameters
//   NREQ     number of requesters (2..8)
//   W        operand width
//   MUL_LAT  edges after the load edge at which mul_p is sampled
// Ports
//   clk      system clock, rising edge
//   reset    asynchronous, active-low reset
//   bus      mult_sched_if slave modport (requester and core signals)
// Build option
//   MULT_SCHED_ZERO_BYPASS_EN  when defined, a winner with a zero operand is
//   answered with 0 two cycles after the request, without using the core.
module mult_sched #(
  parameter int NREQ    = 4,
  parameter int W       = 8,
  parameter int MUL_LAT = 11
) (
  input  logic         clk,
  input  logic         reset,
  mult_sched_if.slave  bus
);

  localparam int PW = $clog2(NREQ);
  localparam int CW = $clog2(MUL_LAT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MUL_LAT - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN
  } state_t;

  state_t          state, state_next;
  logic [PW-1:0]   ptr, ptr_next;
  logic [PW-1:0]   owner, owner_next;
  logic [CW-1:0]   cnt, cnt_next;
  logic [NREQ-1:0] gnt_next;
  logic [NREQ-1:0] res_valid_next;
  logic [2*W-1:0]  res_out_next;
  logic [W-1:0]    mul_a_next, mul_b_next;

  logic            found_hi, found_lo, win_found;
  logic [PW-1:0]   idx_hi, idx_lo, win_idx;
  logic [W-1:0]    win_a, win_b;

`ifdef MULT_SCHED_ZERO_BYPASS_EN
  logic            zero_q, zero_next;
`endif

  assign bus.busy     = (state != IDLE);
  assign bus.mul_load = (state == LOAD);

  // Round-robin pick: the lowest requesting index at or above ptr wins;
  // if none exists, the search wraps to the lowest requesting index overall.
  // Scanning downward lets the last hit be the lowest index.
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    idx_hi   = '0;
    idx_lo   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (bus.req[k]) begin
        found_lo = 1'b1;
        idx_lo   = PW'(k);
        if (PW'(k) >= ptr) begin
          found_hi = 1'b1;
          idx_hi   = PW'(k);
        end
      end
    end
    win_found = found_hi | found_lo;
    win_idx   = found_hi ? idx_hi : idx_lo;
    win_a     = '0;
    win_b     = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (PW'(k) == win_idx) begin
        win_a = bus.a_in[k*W +: W];
        win_b = bus.b_in[k*W +: W];
      end
    end
  end

  // Next-state and datapath update. The result cycle returns to IDLE, so a
  // waiting request is arbitrated in that same cycle with the advanced ptr.
  always_comb begin
    state_next     = state;
    ptr_next       = ptr;
    owner_next     = owner;
    cnt_next       = cnt;
    gnt_next       = bus.gnt;
    res_valid_next = '0;
    res_out_next   = bus.res_out;
    mul_a_next     = bus.mul_a;
    mul_b_next     = bus.mul_b;
`ifdef MULT_SCHED_ZERO_BYPASS_EN
    zero_next      = zero_q;
`endif

    case (state)
      IDLE: begin
        if (win_found) begin
          for (int k = 0; k < NREQ; k++) begin
            gnt_next[k] = (PW'(k) == win_idx);
          end
          owner_next = win_idx;
          mul_a_next = win_a;
          mul_b_next = win_b;
`ifdef MULT_SCHED_ZERO_BYPASS_EN
          // A zero operand jumps straight to the final RUN cycle so the
          // result appears one cycle after the grant without a core load.
          if ((win_a == '0) || (win_b == '0)) begin
            zero_next  = 1'b1;
            cnt_next   = CNT_LAST;
            state_next = RUN;
          end else begin
            zero_next  = 1'b0;
            state_next = LOAD;
          end
`else
          state_next = LOAD;
`endif
        end
      end

      LOAD: begin
        cnt_next   = '0;
        state_next = RUN;
      end

      RUN: begin
        if (cnt == CNT_LAST) begin
`ifdef MULT_SCHED_ZERO_BYPASS_EN
          res_out_next = zero_q ? '0 : bus.mul_p;
`else
          res_out_next = bus.mul_p;
`endif
          res_valid_next = bus.gnt;
          gnt_next       = '0;
          ptr_next       = (owner == PW'(NREQ - 1)) ? '0 : owner + 1'b1;
          state_next     = IDLE;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any operation in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      ptr           <= '0;
      owner         <= '0;
      cnt           <= '0;
      bus.gnt       <= '0;
      bus.res_valid <= '0;
      bus.res_out   <= '0;
      bus.mul_a     <= '0;
      bus.mul_b     <= '0;
`ifdef MULT_SCHED_ZERO_BYPASS_EN
      zero_q        <= 1'b0;
`endif
    end else begin
      state         <= state_next;
      ptr           <= ptr_next;
      owner         <= owner_next;
      cnt           <= cnt_next;
      bus.gnt       <= gnt_next;
      bus.res_valid <= res_valid_next;
      bus.res_out   <= res_out_next;
      bus.mul_a     <= mul_a_next;
      bus.mul_b     <= mul_b_next;
`ifdef MULT_SCHED_ZERO_BYPASS_EN
      zero_q        <= zero_next;
`endif
    end
  end

endmodule

// File: tb/tb_mult_sched.sv
// tb_mult_sched
//   Directed bench for mult_sched with a behavioural multiplier core.
//   Expected results go into a scoreboard queue when a request is issued;
//   a monitor pops and compares whenever res_valid is seen.
module tb_mult_sched;

  localparam int NREQ = 4;
  localparam int W    = 8;
  localparam int LAT  = 13;
`ifdef MULT_SCHED_ZERO_BYPASS_EN
  localparam int ZLAT  = 2;
  localparam int ZLOAD = 0;
`else
  localparam int ZLAT  = 13;
  localparam int ZLOAD = 1;
`endif

  typedef struct {
    int idx;
    int prod;
    int cyc;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   testsRun    = 0;
  int   testsFailed = 0;
  int   cycle       = 0;
  int   loadCount   = 0;
  exp_t sbQ[$];
  logic [3:0] coreCnt;

  mult_sched_if #(.NREQ(NREQ), .W(W)) ifc ();

  mult_sched #(.NREQ(NREQ), .W(W), .MUL_LAT(11)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // Behavioural core: the product appears 10 edges after the load edge,
  // computed from the operands the scheduler is holding at that time.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      coreCnt   <= '0;
      ifc.mul_p <= '0;
    end else if (ifc.mul_load) begin
      coreCnt   <= '0;
      ifc.mul_p <= '0;
    end else begin
      if (coreCnt != 4'd15) coreCnt <= coreCnt + 4'd1;
      ifc.mul_p <= (coreCnt >= 4'd9) ? (16'(ifc.mul_a) * 16'(ifc.mul_b)) : 16'd0;
    end
  end

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    testsRun++;
    if (actual != expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Monitor: scoreboard checks on results plus grant/load sanity each cycle.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        if (ifc.mul_load) begin
          loadCount++;
          checkOutput("load_with_gnt", longint'(ifc.gnt != '0), 1);
        end
        if (ifc.gnt != '0) checkOutput("gnt_onehot", $countones(ifc.gnt), 1);
        if (ifc.res_valid != '0) begin
          if (sbQ.size() == 0) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL unexpected_result: res_valid=%b res_out=%0d, expected no result",
                     ifc.res_valid, ifc.res_out);
          end else begin
            e = sbQ.pop_front();
            checkOutput("sb_valid", ifc.res_valid, longint'(1) << e.idx);
            checkOutput("sb_data", ifc.res_out, e.prod);
            checkOutput("sb_cycle", cycle, e.cyc);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation time exceeded, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic waitUntil(input int cyc);
    while (cycle < cyc) step(1);
  endtask

  task automatic applyStimulus(input int k, input int a, input int b);
    ifc.a_in[k*W +: W] = W'(a);
    ifc.b_in[k*W +: W] = W'(b);
    ifc.req[k] = 1'b1;
  endtask

  task automatic expectResult(input int k, input int prod, input int cyc);
    exp_t e;
    e.idx  = k;
    e.prod = prod;
    e.cyc  = cyc;
    sbQ.push_back(e);
  endtask

  task automatic waitDrain(input int budget);
    int n;
    n = 0;
    while (sbQ.size() != 0 && n < budget) begin
      step(1);
      n++;
    end
    if (sbQ.size() != 0) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL drain_timeout: %0d results pending, expected 0", sbQ.size());
      sbQ.delete();
    end
    step(2);
  endtask

  task automatic doReset();
    reset   = 1'b0;
    ifc.req = '0;
    step(2);
    reset = 1'b1;
    step(1);
  endtask

  initial begin : stimulus
    int t0;
    int lc;
    int gntOrder[5];
    gntOrder = '{1, 2, 4, 8, 1};
    ifc.req  = '0;
    ifc.a_in = '0;
    ifc.b_in = '0;
    step(2);

    // Reset state
    checkOutput("rst_gnt", ifc.gnt, 0);
    checkOutput("rst_res_valid", ifc.res_valid, 0);
    checkOutput("rst_res_out", ifc.res_out, 0);
    checkOutput("rst_busy", ifc.busy, 0);
    checkOutput("rst_mul_load", ifc.mul_load, 0);
    checkOutput("rst_mul_a", ifc.mul_a, 0);
    checkOutput("rst_mul_b", ifc.mul_b, 0);
    reset = 1'b1;
    step(1);

    // Single request 13*11
    lc = loadCount;
    applyStimulus(0, 13, 11);
    t0 = cycle;
    expectResult(0, 143, t0 + LAT);
    step(1);
    checkOutput("t1_gnt", ifc.gnt, 1);
    checkOutput("t1_busy", ifc.busy, 1);
    checkOutput("t1_mul_load", ifc.mul_load, 1);
    checkOutput("t1_mul_a", ifc.mul_a, 13);
    checkOutput("t1_mul_b", ifc.mul_b, 11);
    ifc.req = '0;
    step(1);
    checkOutput("t1_load_pulse", ifc.mul_load, 0);
    waitDrain(40);
    checkOutput("t1_loads", loadCount - lc, 1);
    checkOutput("t1_res_hold", ifc.res_out, 143);
    checkOutput("t1_valid_low", ifc.res_valid, 0);
    checkOutput("t1_idle", ifc.busy, 0);

    // All four requesting continuously
    doReset();
    ifc.a_in = '0;
    ifc.b_in = '0;
    applyStimulus(0, 3, 5);
    applyStimulus(1, 10, 20);
    applyStimulus(2, 100, 7);
    applyStimulus(3, 255, 255);
    t0 = cycle;
    expectResult(0, 15, t0 + 13);
    expectResult(1, 200, t0 + 26);
    expectResult(2, 700, t0 + 39);
    expectResult(3, 65025, t0 + 52);
    expectResult(0, 15, t0 + 65);
    for (int k = 0; k < 5; k++) begin
      waitUntil(t0 + 1 + 13 * k);
      checkOutput("t2_gnt_order", ifc.gnt, gntOrder[k]);
    end
    ifc.req = '0;
    waitDrain(40);

    // Operand change after grant
    doReset();
    applyStimulus(0, 200, 3);
    t0 = cycle;
    expectResult(0, 600, t0 + LAT);
    step(1);
    ifc.req = '0;
    step(1);
    ifc.a_in[0 +: W] = 8'd5;
    waitUntil(t0 + 6);
    checkOutput("t3_mul_a_held", ifc.mul_a, 200);
    waitDrain(40);

    // Reset in the middle of RUN, then a fresh request
    doReset();
    applyStimulus(0, 9, 9);
    t0 = cycle;
    step(1);
    ifc.req = '0;
    waitUntil(t0 + 7);
    reset = 1'b0;
    #1;
    checkOutput("t4_gnt", ifc.gnt, 0);
    checkOutput("t4_busy", ifc.busy, 0);
    checkOutput("t4_mul_load", ifc.mul_load, 0);
    checkOutput("t4_mul_a", ifc.mul_a, 0);
    checkOutput("t4_res_valid", ifc.res_valid, 0);
    step(2);
    reset = 1'b1;
    waitUntil(t0 + 20);
    applyStimulus(2, 12, 12);
    t0 = cycle;
    expectResult(2, 144, t0 + LAT);
    step(1);
    checkOutput("t4_regrant", ifc.gnt, 4);
    ifc.req = '0;
    waitDrain(40);

    // Arbitration in the result cycle
    doReset();
    applyStimulus(0, 7, 8);
    t0 = cycle;
    expectResult(0, 56, t0 + LAT);
    step(1);
    ifc.req[0] = 1'b0;
    waitUntil(t0 + 3);
    applyStimulus(1, 6, 9);
    expectResult(1, 54, t0 + 26);
    waitUntil(t0 + 13);
    checkOutput("t5_res_valid", ifc.res_valid, 1);
    checkOutput("t5_gnt_result", ifc.gnt, 0);
    checkOutput("t5_busy_result", ifc.busy, 0);
    step(1);
    checkOutput("t5_gnt_next", ifc.gnt, 2);
    checkOutput("t5_load_next", ifc.mul_load, 1);
    ifc.req = '0;
    waitDrain(40);

    // Zero operand; res_out still holds 54 from the previous result
    lc = loadCount;
    applyStimulus(0, 0, 77);
    t0 = cycle;
    expectResult(0, 0, t0 + ZLAT);
    step(1);
    checkOutput("t6_gnt", ifc.gnt, 1);
    checkOutput("t6_busy", ifc.busy, 1);
    ifc.req = '0;
    waitDrain(40);
    checkOutput("t6_loads", loadCount - lc, ZLOAD);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
